// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and tree helpers for the PLRU controller
package cache_pkg;

    localparam int MAX_WAYS = 64;

    typedef logic [MAX_WAYS-1:0] way_mask_t;
    typedef logic [MAX_WAYS-2:0] tree_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } plru_state_e;

    // Number of tree levels for num_ways leaves.
    function automatic int unsigned plru_levels(input int unsigned num_ways);
        int unsigned lv;
        lv = 0;
        for (int k = 0; k < 7; k++) begin
            if ((32'd1 << k) < num_ways) begin
                lv = k + 1;
            end
        end
        return lv;
    endfunction

    // Point every node on the path to 'way' away from it; other nodes keep their bits.
    function automatic tree_t plru_path_update(input tree_t tree, input int unsigned way,
                                               input int unsigned num_ways);
        tree_t       t;
        int unsigned node;
        int unsigned levels;
        int unsigned dir;
        t      = tree;
        node   = 0;
        levels = plru_levels(num_ways);
        for (int lvl = 0; lvl < 6; lvl++) begin
            if (lvl < levels) begin
                dir     = (way >> (levels - 1 - lvl)) & 32'd1;
                t[node] = (dir == 0);
                node    = 2 * node + 1 + dir;
            end
        end
        return t;
    endfunction

    // Ways below heap node 'node' (leaves are nodes num_ways-1 .. 2*num_ways-2).
    function automatic way_mask_t plru_subtree_mask(input int unsigned node,
                                                    input int unsigned num_ways);
        way_mask_t   m;
        int unsigned depth;
        int unsigned offset;
        int unsigned span;
        m     = '0;
        depth = 0;
        for (int k = 0; k < 7; k++) begin
            if (node + 1 >= (32'd1 << (k + 1))) begin
                depth = k + 1;
            end
        end
        offset = node + 1 - (32'd1 << depth);
        span   = num_ways >> depth;
        if (span == 0) begin
            span = 1;
        end
        for (int i = 0; i < MAX_WAYS; i++) begin
            if ((i < num_ways) && ((i / span) == offset)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/plru_victim_walk.sv
// rtl/plru_victim_walk.sv - combinational victim choice from one PLRU tree
module plru_victim_walk
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    localparam int WAY_W   = $clog2(NUM_WAYS),
    localparam int NODES   = NUM_WAYS - 1,
    localparam int NODE_W  = WAY_W + 1
) (
    input  logic [NODES-1:0]    tree,
    input  logic [NUM_WAYS-1:0] valid_mask,
    input  logic [NUM_WAYS-1:0] lock_mask,
    output logic [WAY_W-1:0]    way,
    output logic                none
);

    // Heap-indexed tree padded to a power of two so node indices need no truncation.
    logic [2*NUM_WAYS-1:0] tree_ext;
    logic [NUM_WAYS-1:0]   sub_mask [2*NUM_WAYS];

    assign tree_ext = {{(NUM_WAYS + 1){1'b0}}, tree};

    for (genvar g = 0; g < 2 * NUM_WAYS; g++) begin : g_mask
        if (g < 2 * NUM_WAYS - 1) begin : g_node
            assign sub_mask[g] = NUM_WAYS'(plru_subtree_mask(g, NUM_WAYS));
        end else begin : g_pad
            assign sub_mask[g] = '0;
        end
    end

    // Invalid unlocked ways win; otherwise walk the tree, steering around fully locked subtrees.
    always_comb begin
        logic              found;
        logic [NODE_W-1:0] node;
        logic [NODE_W-1:0] child_lo;
        logic [NODE_W-1:0] chosen;
        logic [NODE_W-1:0] other;
        way      = '0;
        none     = &lock_mask;
        found    = 1'b0;
        node     = '0;
        child_lo = '0;
        chosen   = '0;
        other    = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_mask[i] && !lock_mask[i]) begin
                way   = WAY_W'(i);
                found = 1'b1;
            end
        end
        if (!found && !none) begin
            for (int lvl = 0; lvl < WAY_W; lvl++) begin
                child_lo = NODE_W'({node, 1'b1});
                if (tree_ext[node]) begin
                    chosen = child_lo + 1'b1;
                    other  = child_lo;
                end else begin
                    chosen = child_lo;
                    other  = child_lo + 1'b1;
                end
                if ((lock_mask & sub_mask[chosen]) == sub_mask[chosen]) begin
                    chosen = other;
                end
                node = chosen;
            end
            way = WAY_W'(node - NODE_W'(NUM_WAYS - 1));
        end
    end

endmodule

// File: rtl/tree_plru.sv
// rtl/tree_plru.sv - per-set tree pseudo-LRU state, victim selection and flush sweep
module tree_plru
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 16,
    localparam int WAY_W   = $clog2(NUM_WAYS),
    localparam int SET_W   = $clog2(NUM_SETS),
    localparam int NODES   = NUM_WAYS - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_req,
    output logic                init_busy,
    input  logic                acc_valid,
    input  logic [SET_W-1:0]    acc_set,
    input  logic [WAY_W-1:0]    acc_way,
    input  logic                vic_req,
    input  logic [SET_W-1:0]    vic_set,
    input  logic [NUM_WAYS-1:0] vic_valid_mask,
    input  logic [NUM_WAYS-1:0] vic_lock_mask,
    output logic                vic_rsp_valid,
    output logic [WAY_W-1:0]    vic_way,
    output logic                vic_none
);

    plru_state_e      state;
    plru_state_e      state_d;
    logic [SET_W-1:0] sweep_cnt;
    logic [SET_W-1:0] sweep_cnt_d;

    logic [NODES-1:0] tree_mem [NUM_SETS];
    logic [NODES-1:0] upd_tree;
    logic [NODES-1:0] vic_tree;
    logic             acc_en;
    logic             vic_en;
    logic [WAY_W-1:0] walk_way;
    logic             walk_none;

    assign init_busy = (state == SWEEP);
    assign acc_en    = acc_valid && (state == IDLE);
    assign vic_en    = vic_req && (state == IDLE);

    assign upd_tree = NODES'(plru_path_update(tree_t'(tree_mem[acc_set]),
                                              int'(acc_way), NUM_WAYS));

    // Same-set access forwards its updated tree so the victim sees the new path.
    assign vic_tree = (acc_en && (acc_set == vic_set)) ? upd_tree : tree_mem[vic_set];

    plru_victim_walk #(
        .NUM_WAYS (NUM_WAYS)
    ) u_walk (
        .tree       (vic_tree),
        .valid_mask (vic_valid_mask),
        .lock_mask  (vic_lock_mask),
        .way        (walk_way),
        .none       (walk_none)
    );

    // Sweep state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sweep_cnt <= '0;
        end else begin
            state     <= state_d;
            sweep_cnt <= sweep_cnt_d;
        end
    end

    // Sweep sequencing: one set per cycle, set 0 first, back to IDLE after the last set.
    always_comb begin
        state_d     = state;
        sweep_cnt_d = sweep_cnt;
        case (state)
            IDLE: begin
                if (init_req) begin
                    state_d     = SWEEP;
                    sweep_cnt_d = '0;
                end
            end
            SWEEP: begin
                if (sweep_cnt == SET_W'(NUM_SETS - 1)) begin
                    state_d     = IDLE;
                    sweep_cnt_d = '0;
                end else begin
                    sweep_cnt_d = sweep_cnt + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                sweep_cnt_d = '0;
            end
        endcase
    end

    // Tree storage: sweep clears, otherwise accesses rewrite their path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                tree_mem[s] <= '0;
            end
        end else if (state == SWEEP) begin
            tree_mem[sweep_cnt] <= '0;
        end else if (acc_en) begin
            tree_mem[acc_set] <= upd_tree;
        end
    end

    // Registered victim response; way/none hold until the next accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vic_rsp_valid <= 1'b0;
            vic_way       <= '0;
            vic_none      <= 1'b0;
        end else begin
            vic_rsp_valid <= vic_en;
            if (vic_en) begin
                vic_way  <= walk_way;
                vic_none <= walk_none;
            end
        end
    end

endmodule

// File: tb/tb_tree_plru.sv
// tb/tb_tree_plru.sv - directed scoreboard bench for tree_plru
module tb_tree_plru;

    localparam int NUM_WAYS = 4;
    localparam int NUM_SETS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_req = 1'b0;
    logic       init_busy;
    logic       acc_valid = 1'b0;
    logic [3:0] acc_set = '0;
    logic [1:0] acc_way = '0;
    logic       vic_req = 1'b0;
    logic [3:0] vic_set = '0;
    logic [3:0] vic_valid_mask = '0;
    logic [3:0] vic_lock_mask = '0;
    logic       vic_rsp_valid;
    logic [1:0] vic_way;
    logic       vic_none;

    tree_plru #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NUM_SETS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_req       (init_req),
        .init_busy      (init_busy),
        .acc_valid      (acc_valid),
        .acc_set        (acc_set),
        .acc_way        (acc_way),
        .vic_req        (vic_req),
        .vic_set        (vic_set),
        .vic_valid_mask (vic_valid_mask),
        .vic_lock_mask  (vic_lock_mask),
        .vic_rsp_valid  (vic_rsp_valid),
        .vic_way        (vic_way),
        .vic_none       (vic_none)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [1:0]  way;
        logic        none;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          busy_cycles;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                checks++;
                assert (vic_rsp_valid === 1'b1) else begin
                    errors++;
                    $error("FAIL %s rsp_valid got %0b want 1", mon_e.tag, vic_rsp_valid);
                end
                checks++;
                assert ({vic_none, vic_way} === {mon_e.none, mon_e.way}) else begin
                    errors++;
                    $error("FAIL %s none/way got %0b/%0d want %0b/%0d",
                           mon_e.tag, vic_none, vic_way, mon_e.none, mon_e.way);
                end
            end else begin
                checks++;
                assert (vic_rsp_valid === 1'b0) else begin
                    errors++;
                    $error("FAIL unexpected_rsp rsp_valid got %0b want 0 at cycle %0d",
                           vic_rsp_valid, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        acc_valid = 1'b0;
        vic_req   = 1'b0;
        init_req  = 1'b0;
    endtask

    task automatic acc(input logic [3:0] s, input logic [1:0] w);
        acc_valid = 1'b1;
        acc_set   = s;
        acc_way   = w;
    endtask

    task automatic vic(input logic [3:0] s, input logic [3:0] vm, input logic [3:0] lm,
                       input logic [1:0] ew, input logic en, input string tag);
        vic_req        = 1'b1;
        vic_set        = s;
        vic_valid_mask = vm;
        vic_lock_mask  = lm;
        sb.push_back('{due: cyc + 1, way: ew, none: en, tag: tag});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #23;
        checks++;
        assert ({init_busy, vic_rsp_valid, vic_way, vic_none} === 5'b0) else begin
            errors++;
            $error("FAIL reset_outputs got %b want 00000",
                   {init_busy, vic_rsp_valid, vic_way, vic_none});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fresh tree, all valid: root path leads to way 0.
        vic(4'd3, 4'hF, 4'h0, 2'd0, 1'b0, "t1_reset_victim");
        tick();

        // Path updates and set independence.
        acc(4'd3, 2'd0);
        tick();
        vic(4'd3, 4'hF, 4'h0, 2'd2, 1'b0, "t2_after_way0");
        tick();
        acc(4'd3, 2'd2);
        tick();
        vic(4'd3, 4'hF, 4'h0, 2'd1, 1'b0, "t2_after_way2");
        tick();
        vic(4'd4, 4'hF, 4'h0, 2'd0, 1'b0, "t2_other_set");
        tick();
        vic(4'd3, 4'hF, 4'b0010, 2'd0, 1'b0, "t2_locked_leaf");
        tick();
        vic(4'd3, 4'hF, 4'h0, 2'd1, 1'b0, "t2_hold_src");
        tick();
        tick();
        tick();
        checks++;
        assert ({vic_none, vic_way} === 3'b001) else begin
            errors++;
            $error("FAIL t2_hold none/way got %0b/%0d want 0/1", vic_none, vic_way);
        end

        // Bypass: different set first, then same set.
        acc(4'd6, 2'd0);
        vic(4'd5, 4'hF, 4'h0, 2'd0, 1'b0, "t3_no_bypass");
        tick();
        acc(4'd5, 2'd0);
        vic(4'd5, 4'hF, 4'h0, 2'd2, 1'b0, "t3_bypass");
        tick();

        // Back-to-back requests.
        vic(4'd3, 4'hF, 4'h0, 2'd1, 1'b0, "b2b_a");
        tick();
        vic(4'd5, 4'hF, 4'h0, 2'd2, 1'b0, "b2b_b");
        tick();
        vic(4'd6, 4'hF, 4'h0, 2'd2, 1'b0, "b2b_c");
        tick();

        // Locks and invalid-way priority on an untouched set.
        vic(4'd10, 4'hF, 4'b0001, 2'd1, 1'b0, "t4_lock0");
        tick();
        vic(4'd10, 4'hF, 4'b0011, 2'd2, 1'b0, "t4_lock01");
        tick();
        vic(4'd10, 4'hF, 4'b1111, 2'd0, 1'b1, "t4_all_locked");
        tick();
        vic(4'd10, 4'b1011, 4'h0, 2'd2, 1'b0, "t4_invalid_pref");
        tick();
        vic(4'd10, 4'b0000, 4'b0001, 2'd1, 1'b0, "t4_invalid_skip_locked");
        tick();
        tick();

        // Flush sweep: busy length, ignored requests/accesses/re-init.
        init_req = 1'b1;
        tick();
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!init_busy) break;
            busy_cycles++;
            vic_req   = 1'b1;
            vic_set   = 4'd3;
            acc_valid = 1'b1;
            acc_set   = 4'd3;
            acc_way   = 2'd0;
            if (busy_cycles == 2) init_req = 1'b1;
            tick();
        end
        checks++;
        assert (busy_cycles === 16) else begin
            errors++;
            $error("FAIL t5_busy_len got %0d want 16", busy_cycles);
        end
        for (int s = 0; s < NUM_SETS; s++) begin
            vic(4'(s), 4'hF, 4'h0, 2'd0, 1'b0, "t5_post_sweep");
            tick();
        end
        tick();

        // Async reset in the middle of a sweep.
        acc(4'd12, 2'd0);
        tick();
        init_req = 1'b1;
        tick();
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        assert ({init_busy, vic_rsp_valid} === 2'b00) else begin
            errors++;
            $error("FAIL t6_reset_abort busy/rsp got %b want 00", {init_busy, vic_rsp_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vic(4'd12, 4'hF, 4'h0, 2'd0, 1'b0, "t6_tree_cleared");
        tick();
        acc(4'd12, 2'd0);
        tick();
        vic(4'd12, 4'hF, 4'h0, 2'd2, 1'b0, "t6_traffic_ok");
        tick();
        tick();
        tick();

        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL sb_drain outstanding got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tree_plru.md
Name: tree_plru

Overview:
Parametrised tree pseudo-LRU replacement controller for the N-way set-associative cache. It keeps one (NUM_WAYS-1)-bit PLRU tree per set and updates the path on every hit or fill. On request it returns a registered victim way, preferring invalid ways and skipping locked ways. It also provides a sequenced flush/re-init of all sets. It sits beside the tag/valid arrays in the cache controller, and the controller FSM drives both the access and victim ports.

Parameters:
NUM_WAYS, 4, associativity; power of 2, >= 2.
NUM_SETS, 16, number of sets; power of 2, >= 2.
(Derived localparams: WAY_W = $clog2(NUM_WAYS), SET_W = $clog2(NUM_SETS), NODES = NUM_WAYS-1.)

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous reset, active-low.
init_req  in  1  pulse: start a clear of all PLRU trees.
init_busy  out  1  high while the clear sweep runs.
acc_valid  in  1  hit or fill occurred this cycle; update the tree.
acc_set  in  SET_W  set of the access.
acc_way  in  WAY_W  way touched.
vic_req  in  1  request a victim for vic_set.
vic_set  in  SET_W  set to choose a victim in.
vic_valid_mask  in  NUM_WAYS  bit i = 1 means way i holds a valid line.
vic_lock_mask  in  NUM_WAYS  bit i = 1 means way i must not be chosen.
vic_rsp_valid  out  1  victim result valid; 1-cycle pulse.
vic_way  out  WAY_W  chosen victim way.
vic_none  out  1  all ways locked; no victim exists.

Behaviour:
- Reset (async, rst_n=0):
  - All tree bits = 0.
  - FSM = IDLE, sweep counter = 0.
  - init_busy = 0, vic_rsp_valid = 0, vic_way = 0, vic_none = 0.
  - Reset asserted mid-sweep aborts the sweep immediately.
- Tree encoding: heap-indexed nodes; node 0 is the root, and node n has children 2n+1 and 2n+2.
  - Node bit = 0 means the victim search descends into the lower-way child; 1 means the upper-way child.
- Update (acc_valid=1, FSM IDLE):
  - At the next edge, every node on the path to acc_way is set to point away from acc_way.
  - A node whose left subtree contains acc_way gets bit 1; otherwise it gets bit 0.
  - Nodes off the path are unchanged.
- Victim selection, in priority order:
  1) Lowest-index way with valid=0 and lock=0.
  2) Otherwise walk the tree from the root. At each node, follow the bit unless the whole chosen subtree is locked; in that case take the sibling.
  3) If all ways are locked: vic_none=1 and vic_way=0.
- Victim latency:
  - vic_req sampled at edge k gives vic_rsp_valid=1 with vic_way/vic_none during cycle k+1.
  - vic_way/vic_none hold their value until the next response.
- Bypass: if acc_valid and vic_req target the same set in the same cycle, the victim is computed on the post-update tree.
- Back-to-back: vic_req may be asserted every cycle; each request yields one response.
- Init FSM:
  - IDLE -> SWEEP on init_req.
  - SWEEP clears one set per cycle, set 0 to NUM_SETS-1, then returns to IDLE. Total is NUM_SETS cycles with init_busy=1.
  - init_req during SWEEP is ignored.
- While init_busy=1:
  - acc_valid is ignored.
  - vic_req is ignored; no response is produced.
- Out-of-range values cannot occur because the widths are exact powers of 2.

Decomposition:
- cache_pkg holds:
  - a way_mask_t typedef;
  - the plru_state_e enum {IDLE, SWEEP};
  - functions plru_path_update() and plru_subtree_mask(), both parametrised by NUM_WAYS.
- Sub-module plru_victim_walk (combinational): takes a tree vector plus valid and lock masks and returns the way and none flag. It is instantiated once, and its result is registered in tree_plru.

Test Plan:
1. NUM_WAYS=4, NUM_SETS=16, after reset; vic_req set 3, valid=1111, lock=0000 -> next cycle vic_rsp_valid=1, vic_way=0, vic_none=0.
2. acc way 0 set 3, then vic_req set 3 (all valid) -> vic_way=2. Then acc way 2 set 3, vic_req -> vic_way=1. vic_req set 4 -> vic_way=0, showing sets are independent.
3. Same cycle: acc way 0 set 5 with vic_req set 5 -> vic_way=2 (bypass). With acc to set 6 instead -> vic_way=0.
4. After reset, valid=1111, lock=0001 -> vic_way=1. lock=0011 -> vic_way=2. lock=1111 -> vic_none=1, vic_way=0. valid=1011, lock=0000 -> vic_way=2 (invalid preferred).
5. Touch ways in several sets, then pulse init_req:
   - init_busy is high for exactly 16 cycles.
   - vic_req during the sweep gives no response.
   - After the sweep, every set returns vic_way=0.
6. Drop rst_n asynchronously mid-sweep at sweep set 7 -> init_busy=0 immediately. After release, the tree is all zeros and acc/vic traffic is accepted.
